mult_sched: RTL and testbench
=============================

Name: mult_sched

Overview:
- Round-robin scheduler and sequencer that shares one 8-bit signed shift-add multiplier datapath (registers A, B, S with add/sub/shift controls) between two requesters.
- Arbitrates requests, loads the winning operands into the datapath and steps it through 8 multiplier bits.
- Captures the 16-bit {A,B} product and returns it to the granted requester with a done pulse.
- Sits between the datapath and the front-end units that issue multiplies.

Parameters:
- NREQ, 2, number of requesters (fixed at 2 for this revision)
- W, 8, operand width; bit counter runs 0..W-1

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous active-low reset (asserted when 0)
- Req  in  2  per-requester request level; bit i = requester i
- OpS0, OpB0  in  8 each  multiplicand/multiplier from requester 0
- OpS1, OpB1  in  8 each  multiplicand/multiplier from requester 1
- Ack  out  2  one-hot, one-cycle grant pulse
- Done  out  2  one-hot, one-cycle completion pulse
- Result  out  16  product; valid in the Done cycle, held until next capture
- Busy  out  1  high when state is not IDLE
- Dp_S, Dp_B  out  8 each  registered operands presented to datapath
- Dp_Load  out  1  load S<=Dp_S, B<=Dp_B, A<=0 (one cycle)
- Dp_Add  out  1  A <= A + S (sign-extended 9-bit add)
- Dp_Sub  out  1  A <= A - S
- Dp_Shift  out  1  arithmetic right shift of {X,A,B}
- Dp_M  in  1  datapath B[0]
- Dp_Result  in  16  datapath {A,B}

Behaviour:
- Reset: state IDLE; Ack, Done, Busy, Dp_Load/Add/Sub/Shift = 0; Result, Dp_S, Dp_B = 0; count = 0; last-served pointer = 1, so requester 0 wins first contention. Synchronous reset mid-operation aborts the multiply with no Done pulse.
- States: IDLE, GRANT, LOAD, EVAL, SHIFT, CAPTURE. Exactly one Dp_* control is high per cycle, or none.
- IDLE: if any Req bit is high, pick the winner.
  - Single request: that requester wins.
  - Both requesting: the requester not equal to the last-served pointer wins.
  - Latch the winner's OpS/OpB into Dp_S/Dp_B, record grant index g, go to GRANT.
- GRANT: Ack[g] = 1 for this cycle only; update last-served pointer to g; go to LOAD.
- LOAD: Dp_Load = 1; count <= 0; go to EVAL.
- EVAL:
  - Dp_M = 1: assert Dp_Add if count < 7, or Dp_Sub if count = 7; go to SHIFT.
  - Dp_M = 0: assert Dp_Shift; if count = 7 go to CAPTURE, else count++ and stay in EVAL.
- SHIFT: Dp_Shift = 1; if count = 7 go to CAPTURE, else count++ and go to EVAL.
- CAPTURE: Result <= Dp_Result; Done[g] <= 1, visible the next cycle (IDLE); go to IDLE.
- Done/Ack timing: Done coincides with the first IDLE cycle, and a new arbitration may occur in that same cycle.
- Latency: with Ack at cycle 0, Done is at cycle 11 + popcount(OpB). Range is 11 to 19 cycles.
- Request handshake:
  - Requester holds Req until it sees Ack, then may drop it.
  - Req still high in IDLE after its own Done is a new request, subject to round-robin.
  - Req dropped before Ack means the request is never served.
  - Operand changes after the latch edge are ignored.
- Busy = 1 in GRANT through CAPTURE; Req is ignored while Busy.
- Arithmetic: two's-complement; the final bit uses subtract so that OpB is treated as signed. Result is the 16-bit signed product OpS*OpB; no overflow is possible.

Test Plan:
- Req=01, OpS0=0x07, OpB0=0x03 -> Ack=01 at cycle 0, Done=01 at cycle 13, Result=0x0015.
- Req=10, OpS1=0xFE, OpB1=0x03 -> Ack=10, Result=0xFFFA, Done at cycle 13.
- Req=01, OpS0=0x01, OpB0=0xFF -> Dp_Sub pulses exactly once on the final bit, Result=0xFFFF, Done at cycle 19. Separately, OpS0=0x80, OpB0=0x80 -> Result=0x4000.
- Req=11 held continuously after reset -> grants alternate 0,1,0,1; each Done index matches the preceding Ack index; no IDLE gap longer than 1 cycle between jobs.
- Req=01, OpB0=0x00 -> no Add/Sub pulses, exactly 8 Dp_Shift pulses, Result=0x0000, Done at cycle 11.
- Reset driven low during EVAL of a job -> next cycle all outputs 0, no Done for the aborted job; Req=11 afterwards grants requester 0 first.

Source files
------------

// File: rtl/mult_sched.sv
// mult_sched: round-robin arbiter and sequencer that shares one signed
// shift-add multiplier datapath between two requesters. The datapath sits
// outside this block. It holds S, B and a sign-extended accumulator A.
module mult_sched #(
  parameter int NREQ = 2,
  parameter int W    = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   Req,
  input  logic [W-1:0]      OpS0,
  input  logic [W-1:0]      OpB0,
  input  logic [W-1:0]      OpS1,
  input  logic [W-1:0]      OpB1,
  output logic [NREQ-1:0]   Ack,
  output logic [NREQ-1:0]   Done,
  output logic [2*W-1:0]    Result,
  output logic              Busy,
  output logic [W-1:0]      Dp_S,
  output logic [W-1:0]      Dp_B,
  output logic              Dp_Load,
  output logic              Dp_Add,
  output logic              Dp_Sub,
  output logic              Dp_Shift,
  input  logic              Dp_M,
  input  logic [2*W-1:0]    Dp_Result
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LastBit = CW'(W - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LOAD,
    EVAL,
    SHIFT,
    CAPTURE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            grantIdx_q, grantIdx_d;
  logic            lastServed_q, lastServed_d;
  logic [W-1:0]    opS_q, opS_d;
  logic [W-1:0]    opB_q, opB_d;
  logic [2*W-1:0]  result_q, result_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            winner;

  assign Dp_S   = opS_q;
  assign Dp_B   = opB_q;
  assign Result = result_q;
  assign Done   = done_q;
  assign Busy   = (state_q != IDLE);

  // State and datapath-facing registers; reset leaves requester 1 as last
  // served so requester 0 wins the first contention.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      grantIdx_q   <= 1'b0;
      lastServed_q <= 1'b1;
      opS_q        <= '0;
      opB_q        <= '0;
      result_q     <= '0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      grantIdx_q   <= grantIdx_d;
      lastServed_q <= lastServed_d;
      opS_q        <= opS_d;
      opB_q        <= opB_d;
      result_q     <= result_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic and the one-hot datapath controls for the current state.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    grantIdx_d   = grantIdx_q;
    lastServed_d = lastServed_q;
    opS_d        = opS_q;
    opB_d        = opB_q;
    result_d     = result_q;
    done_d       = '0;
    winner       = 1'b0;
    Ack          = '0;
    Dp_Load      = 1'b0;
    Dp_Add       = 1'b0;
    Dp_Sub       = 1'b0;
    Dp_Shift     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Req != '0) begin
          if (Req[0] && Req[1]) begin
            winner = ~lastServed_q;
          end else begin
            winner = Req[1];
          end
          grantIdx_d = winner;
          opS_d      = winner ? OpS1 : OpS0;
          opB_d      = winner ? OpB1 : OpB0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        Ack[grantIdx_q] = 1'b1;
        lastServed_d    = grantIdx_q;
        state_d         = LOAD;
      end
      LOAD: begin
        Dp_Load = 1'b1;
        count_d = '0;
        state_d = EVAL;
      end
      EVAL: begin
        if (Dp_M) begin
          if (count_q == LastBit) begin
            Dp_Sub = 1'b1;
          end else begin
            Dp_Add = 1'b1;
          end
          state_d = SHIFT;
        end else begin
          Dp_Shift = 1'b1;
          if (count_q == LastBit) begin
            state_d = CAPTURE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      SHIFT: begin
        Dp_Shift = 1'b1;
        if (count_q == LastBit) begin
          state_d = CAPTURE;
        end else begin
          count_d = count_q + CW'(1);
          state_d = EVAL;
        end
      end
      CAPTURE: begin
        result_d           = Dp_Result;
        done_d[grantIdx_q] = 1'b1;
        state_d            = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: drives mult_sched with directed and random requests and
// emulates the shared multiplier datapath. A transaction-level model predicts
// the grant order, the completion timing and the signed product.
module tb_mult_sched;

  logic        Clk;
  logic        Reset;
  logic [1:0]  Req;
  logic [7:0]  OpS0, OpB0, OpS1, OpB1;
  logic [1:0]  Ack, Done;
  logic [15:0] Result;
  logic        Busy;
  logic [7:0]  Dp_S, Dp_B;
  logic        Dp_Load, Dp_Add, Dp_Sub, Dp_Shift;
  logic        Dp_M;
  logic [15:0] Dp_Result;

  int checkCount = 0;
  int failCount  = 0;

  mult_sched #(.NREQ(2), .W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req),
    .OpS0(OpS0), .OpB0(OpB0), .OpS1(OpS1), .OpB1(OpB1),
    .Ack(Ack), .Done(Done), .Result(Result), .Busy(Busy),
    .Dp_S(Dp_S), .Dp_B(Dp_B),
    .Dp_Load(Dp_Load), .Dp_Add(Dp_Add), .Dp_Sub(Dp_Sub), .Dp_Shift(Dp_Shift),
    .Dp_M(Dp_M), .Dp_Result(Dp_Result)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Shared datapath: 9-bit accumulator {X,A}, multiplier B, multiplicand S.
  logic signed [8:0] dpA = '0;
  logic [7:0]        dpB = '0;
  logic [7:0]        dpS = '0;

  assign Dp_M      = dpB[0];
  assign Dp_Result = {dpA[7:0], dpB};

  always @(posedge Clk) begin
    if (Dp_Load) begin
      dpA <= '0;
      dpB <= Dp_B;
      dpS <= Dp_S;
    end else if (Dp_Add) begin
      dpA <= dpA + $signed({dpS[7], dpS});
    end else if (Dp_Sub) begin
      dpA <= dpA - $signed({dpS[7], dpS});
    end else if (Dp_Shift) begin
      dpA <= {dpA[8], dpA[8:1]};
      dpB <= {dpA[0], dpB[7:1]};
    end
  end

  // Reference model state: one job in flight at most.
  bit          resetPrev = 1'b1;
  bit          mPend = 1'b0;
  bit          mBusy = 1'b0;
  int          mGrant = 0;
  int          mLast = 1;
  int          mCyc = 0;
  int          mLat = 0;
  logic [7:0]  expS, expB;
  logic [15:0] expProd;
  logic [15:0] mResult = '0;
  int          nLoad, nAdd, nSub, nShift;

  // Model step at each falling edge, comparing against what the DUT shows.
  always @(negedge Clk) begin
    logic [1:0] doneExp;
    int         win;
    int         prod;
    doneExp = 2'b00;
    checkOutput("ctlOneHot", 32'($countones({Dp_Load, Dp_Add, Dp_Sub, Dp_Shift}) <= 1), 32'd1);
    if (resetPrev) begin
      checkOutput("rstCtl", {Ack, Done, Busy, Dp_Load, Dp_Add, Dp_Sub, Dp_Shift}, 32'd0);
      checkOutput("rstResult", Result, 32'd0);
      checkOutput("rstDpOps", {Dp_S, Dp_B}, 32'd0);
      mPend = 1'b0;
      mBusy = 1'b0;
      mLast = 1;
      mResult = '0;
    end else begin
      if (mPend) begin
        checkOutput("ackIdx", Ack, 32'(1 << mGrant));
        checkOutput("dpOps", {Dp_S, Dp_B}, {expS, expB});
        mPend = 1'b0;
        mBusy = 1'b1;
        mCyc = 0;
        mLast = mGrant;
        nLoad = 0; nAdd = 0; nSub = 0; nShift = 0;
      end else begin
        checkOutput("ackIdle", Ack, 32'd0);
        if (mBusy) begin
          mCyc++;
          if (mCyc == mLat) begin
            doneExp = 2'(1 << mGrant);
            mResult = expProd;
            mBusy = 1'b0;
            checkOutput("nLoad", nLoad, 1);
            checkOutput("nShift", nShift, 8);
            checkOutput("nAddSub", nAdd + nSub, $countones(expB));
            checkOutput("nSub", nSub, 32'(expB[7]));
          end
        end
      end
      checkOutput("doneIdx", Done, 32'(doneExp));
      checkOutput("result", Result, 32'(mResult));
      checkOutput("busy", Busy, 32'(mBusy));
      if (mBusy) begin
        nLoad  += int'(Dp_Load);
        nAdd   += int'(Dp_Add);
        nSub   += int'(Dp_Sub);
        nShift += int'(Dp_Shift);
      end else begin
        checkOutput("idleCtl", {Dp_Load, Dp_Add, Dp_Sub, Dp_Shift}, 32'd0);
      end
    end
    if (Reset && !mBusy && !mPend && Req != 2'b00) begin
      if (Req == 2'b11) win = (mLast == 0) ? 1 : 0;
      else              win = Req[1] ? 1 : 0;
      mGrant = win;
      expS = win ? OpS1 : OpS0;
      expB = win ? OpB1 : OpB0;
      prod = $signed(expS) * $signed(expB);
      expProd = prod[15:0];
      mLat = 11 + $countones(expB);
      mPend = 1'b1;
    end
    resetPrev = !Reset;
  end

  function automatic logic [7:0] pickOperand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'h7F;
      default: return r[7:0];
    endcase
  endfunction

  task automatic applyStimulus(input logic [1:0] mask, input logic [7:0] s0, b0, s1, b1);
    @(posedge Clk); #1;
    OpS0 = s0; OpB0 = b0; OpS1 = s1; OpB1 = b1;
    Req = mask;
  endtask

  task automatic waitAck(output logic [1:0] seen);
    seen = 2'b00;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (Ack != 2'b00) begin
        seen = Ack;
        break;
      end
    end
    if (seen == 2'b00) checkOutput("ackTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitDone(output logic [1:0] seen, output int cycles);
    seen = 2'b00;
    cycles = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk); #1;
      if (Done != 2'b00) begin
        seen = Done;
        cycles = k;
        break;
      end
    end
    if (seen == 2'b00) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic runJob(input string tag, input logic [1:0] mask,
                        input logic [7:0] s0, b0, s1, b1,
                        input logic [1:0] expAck, input logic [15:0] expResult,
                        input int expLatency);
    logic [1:0] a, d;
    int cyc;
    applyStimulus(mask, s0, b0, s1, b1);
    waitAck(a);
    checkOutput({tag, "Ack"}, a, expAck);
    Req = 2'b00;
    waitDone(d, cyc);
    checkOutput({tag, "Done"}, d, expAck);
    checkOutput({tag, "Latency"}, cyc, expLatency);
    checkOutput({tag, "Result"}, Result, expResult);
  endtask

  task automatic waitModelIdle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge Clk); #1;
      if (!mBusy && !mPend) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) checkOutput("drainTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d", checkCount);
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios first, then a randomized run with occasional resets.
  initial begin
    logic [1:0] a, d;
    int cyc;
    Reset = 1'b0;
    Req = 2'b00;
    OpS0 = '0; OpB0 = '0; OpS1 = '0; OpB1 = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;

    runJob("r0x7x3", 2'b01, 8'h07, 8'h03, 8'h00, 8'h00, 2'b01, 16'h0015, 13);
    runJob("r1xFEx3", 2'b10, 8'h00, 8'h00, 8'hFE, 8'h03, 2'b10, 16'hFFFA, 13);
    runJob("r0x1xFF", 2'b01, 8'h01, 8'hFF, 8'h00, 8'h00, 2'b01, 16'hFFFF, 19);
    runJob("r0x80x80", 2'b01, 8'h80, 8'h80, 8'h00, 8'h00, 2'b01, 16'h4000, 12);
    runJob("r0xB0", 2'b01, 8'h5A, 8'h00, 8'h00, 8'h00, 2'b01, 16'h0000, 11);

    // Both requesters held: model checks alternation and back-to-back grants.
    applyStimulus(2'b11, 8'h03, 8'h05, 8'hFE, 8'h81);
    repeat (90) @(posedge Clk);
    #1 Req = 2'b00;
    waitModelIdle();

    // Abort a job mid-EVAL, then contend immediately.
    applyStimulus(2'b01, 8'h33, 8'h00, 8'h00, 8'h00);
    waitAck(a);
    Req = 2'b00;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk);
    #1 Reset = 1'b1;
    OpS0 = 8'h0A; OpB0 = 8'h0B; OpS1 = 8'h05; OpB1 = 8'h05;
    Req = 2'b11;
    waitAck(a);
    checkOutput("postRstGrant", a, 2'b01);
    Req = 2'b00;
    waitDone(d, cyc);
    checkOutput("postRstDone", d, 2'b01);
    checkOutput("postRstResult", Result, 16'h006E);

    for (int c = 0; c < 3000; c++) begin
      @(posedge Clk); #1;
      if (!Reset) Reset = 1'b1;
      else if ($urandom_range(0, 599) == 0) Reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
        bit newOps;
        newOps = 1'b0;
        if (Req[i]) begin
          if (Ack[i]) begin
            newOps = 1'b1;
            if ($urandom_range(0, 3) != 0) Req[i] = 1'b0;
          end else if ($urandom_range(0, 39) == 0) begin
            Req[i] = 1'b0;
          end
        end else begin
          newOps = 1'b1;
          if ($urandom_range(0, 2) == 0) Req[i] = 1'b1;
        end
        if (newOps) begin
          if (i == 0) begin OpS0 = pickOperand(); OpB0 = pickOperand(); end
          else        begin OpS1 = pickOperand(); OpB1 = pickOperand(); end
        end
      end
    end

    Req = 2'b00;
    Reset = 1'b1;
    waitModelIdle();
    repeat (3) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
